// File: rtl/layer_output_packer.sv
// Collects numInput clamped neuron results into one packed frame, pulses o_valid
// for a single cycle per frame, then holds off the producer while argmax scans it.
module layer_output_packer #(
    parameter int numInput   = 10,
    parameter int dataWidth  = 24,
    parameter int outWidth   = 16,
    parameter int holdCycles = 11
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic [dataWidth-1:0]         i_data,
    input  logic                         i_valid,
    output logic                         o_ready,
    input  logic                         i_clear,
    output logic [numInput*outWidth-1:0] o_data,
    output logic                         o_valid,
    output logic                         o_drop,
    output logic [15:0]                  o_frames
);

    localparam int IW = (numInput > 1) ? $clog2(numInput) : 1;
    localparam int HW = (holdCycles > 1) ? $clog2(holdCycles) : 1;

    localparam logic [1:0] ST_COLLECT = 2'd0;
    localparam logic [1:0] ST_EMIT    = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;

    localparam logic [dataWidth-1:0] MAX_V = {{(dataWidth-outWidth){1'b0}}, {outWidth{1'b1}}};

    logic [1:0]                  state_q, state_d;
    logic [IW-1:0]               index_q, index_d;
    logic [HW-1:0]               hold_q, hold_d;
    logic [numInput*outWidth-1:0] data_q, data_d;
    logic                        valid_q, valid_d;
    logic                        drop_q, drop_d;
    logic [15:0]                 frames_q, frames_d;

    logic                        accept;
    logic [outWidth-1:0]         clamp_w;

    assign o_ready = (state_q == ST_COLLECT);
    assign accept  = i_valid & o_ready;

    // Negative results saturate to zero, anything above the unsigned range to all ones.
    always_comb begin
        clamp_w = i_data[outWidth-1:0];
        if (i_data[dataWidth-1]) begin
            clamp_w = '0;
        end else if (i_data > MAX_V) begin
            clamp_w = '1;
        end
    end

    always_comb begin
        state_d  = state_q;
        index_d  = index_q;
        hold_d   = hold_q;
        data_d   = data_q;
        valid_d  = 1'b0;
        drop_d   = drop_q;
        frames_d = frames_q;

        if (i_clear) begin
            state_d = ST_COLLECT;
            index_d = '0;
            hold_d  = '0;
            drop_d  = 1'b0;
        end else begin
            if (i_valid && !o_ready) begin
                drop_d = 1'b1;
            end
            case (state_q)
                ST_COLLECT: begin
                    if (accept) begin
                        for (int unsigned k = 0; k < numInput; k++) begin
                            if (index_q == IW'(k)) begin
                                data_d[k*outWidth +: outWidth] = clamp_w;
                            end
                        end
                        if (index_q == IW'(numInput - 1)) begin
                            index_d = '0;
                            state_d = ST_EMIT;
                            valid_d = 1'b1;
                        end else begin
                            index_d = index_q + 1'b1;
                        end
                    end
                end
                ST_EMIT: begin
                    // Counted on leaving EMIT so a same-cycle clear can cancel it.
                    frames_d = frames_q + 16'd1;
                    if (holdCycles == 0) begin
                        state_d = ST_COLLECT;
                    end else begin
                        state_d = ST_HOLD;
                        hold_d  = HW'(holdCycles - 1);
                    end
                end
                ST_HOLD: begin
                    if (hold_q == '0) begin
                        state_d = ST_COLLECT;
                    end else begin
                        hold_d = hold_q - 1'b1;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_COLLECT;
            index_q  <= '0;
            hold_q   <= '0;
            data_q   <= '0;
            valid_q  <= 1'b0;
            drop_q   <= 1'b0;
            frames_q <= '0;
        end else begin
            state_q  <= state_d;
            index_q  <= index_d;
            hold_q   <= hold_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            drop_q   <= drop_d;
            frames_q <= frames_d;
        end
    end

    assign o_data   = data_q;
    assign o_valid  = valid_q;
    assign o_drop   = drop_q;
    assign o_frames = frames_q;

endmodule

// File: tb/tb_layer_output_packer.sv
// Randomized and directed stimulus for layer_output_packer, checked every cycle
// against a frame-level model built from word counts and a busy-cycle countdown.
module tb_layer_output_packer;

    localparam int NI = 10;
    localparam int DWID = 24;
    localparam int OW = 16;
    localparam int HC = 11;
    localparam int VW = NI * OW;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [DWID-1:0] i_data = '0;
    logic            i_valid = 1'b0;
    logic            i_clear = 1'b0;
    logic            o_ready;
    logic [VW-1:0]   o_data;
    logic            o_valid;
    logic            o_drop;
    logic [15:0]     o_frames;

    layer_output_packer #(
        .numInput  (NI),
        .dataWidth (DWID),
        .outWidth  (OW),
        .holdCycles(HC)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_data  (i_data),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_clear (i_clear),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_drop  (o_drop),
        .o_frames(o_frames)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_bad    = 0;

    // Reference model state
    int m_slots[NI];
    int m_count;     // words accepted into the current frame
    int m_busy;      // cycles remaining with the producer held off
    int m_valid;
    int m_drop;
    int m_frames;

    task automatic check_val(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int clamp_ref(input logic [DWID-1:0] d);
        int sd;
        sd = int'($signed(d));
        if (sd < 0) return 0;
        if (sd > (1 << OW) - 1) return (1 << OW) - 1;
        return sd;
    endfunction

    function automatic logic [VW-1:0] packed_ref();
        logic [VW-1:0] v;
        v = '0;
        for (int k = 0; k < NI; k++) v[k*OW +: OW] = OW'(m_slots[k]);
        return v;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NI; k++) m_slots[k] = 0;
        m_count = 0; m_busy = 0; m_valid = 0; m_drop = 0; m_frames = 0;
    endtask

    // One clock: drive inputs, compare at the falling edge, then advance the model.
    task automatic cyc(input logic v, input logic [DWID-1:0] d, input logic c, input logic rn);
        bit ready;
        i_valid = v; i_data = d; i_clear = c; rst_n = rn;
        @(negedge clk);
        check_val("ready",  VW'(o_ready),  VW'(m_busy == 0));
        check_val("valid",  VW'(o_valid),  VW'(m_valid));
        check_val("drop",   VW'(o_drop),   VW'(m_drop));
        check_val("frames", VW'(o_frames), VW'(m_frames & 16'hFFFF));
        check_val("data",   o_data,        packed_ref());
        if (!rn) begin
            model_reset();
        end else if (c) begin
            m_count = 0; m_busy = 0; m_valid = 0; m_drop = 0;
        end else begin
            ready = (m_busy == 0);
            if (m_valid != 0) m_frames++;
            m_valid = 0;
            if (m_busy > 0) m_busy--;
            if (v && ready) begin
                m_slots[m_count] = clamp_ref(d);
                m_count++;
                if (m_count == NI) begin
                    m_count = 0;
                    m_busy  = HC + 1;
                    m_valid = 1;
                end
            end
            if (v && !ready) m_drop = 1;
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [DWID-1:0] rand_data();
        case ($urandom % 4)
            0: return DWID'($urandom % 65536);
            1: return DWID'(-int'($urandom % 100000) - 1);
            2: return DWID'(65536 + ($urandom % 1000000));
            default: return DWID'($urandom);
        endcase
    endfunction

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0, 1'b1);
    endtask

    logic [DWID-1:0] clamp_vec[NI];

    initial begin
        @(posedge clk); #1;
        @(posedge clk); #1;
        model_reset();
        cyc(1'b0, '0, 1'b0, 1'b0);

        // Words 1..10 back to back
        for (int i = 0; i < NI; i++) cyc(1'b1, DWID'(i + 1), 1'b0, 1'b1);
        idle(15);

        // Clamp corners
        clamp_vec[0] = 24'hFFFFFB; clamp_vec[1] = 24'h00FFFF; clamp_vec[2] = 24'h010000;
        clamp_vec[3] = 24'h7FFFFF; clamp_vec[4] = 24'h000123;
        for (int i = 5; i < NI; i++) clamp_vec[i] = '0;
        for (int i = 0; i < NI; i++) cyc(1'b1, clamp_vec[i], 1'b0, 1'b1);
        idle(15);

        // Valid held high across the hold-off window
        for (int i = 0; i < 25; i++) cyc(1'b1, rand_data(), 1'b0, 1'b1);
        idle(3);
        cyc(1'b0, '0, 1'b1, 1'b1);

        // Gappy delivery
        for (int i = 0; i < NI; i++) begin
            cyc(1'b1, rand_data(), 1'b0, 1'b1);
            idle(int'($urandom_range(0, 3)));
        end
        idle(15);

        // Clear after 4 words, then 100..109
        for (int i = 0; i < 4; i++) cyc(1'b1, rand_data(), 1'b0, 1'b1);
        cyc(1'b1, 24'd55, 1'b1, 1'b1);
        for (int i = 0; i < NI; i++) cyc(1'b1, DWID'(100 + i), 1'b0, 1'b1);
        idle(15);

        // Reset mid-frame with valid asserted
        for (int i = 0; i < 6; i++) cyc(1'b1, rand_data(), 1'b0, 1'b1);
        cyc(1'b1, rand_data(), 1'b0, 1'b0);
        cyc(1'b1, rand_data(), 1'b0, 1'b0);
        for (int i = 0; i < NI; i++) cyc(1'b1, DWID'(200 + i), 1'b0, 1'b1);
        idle(15);

        // Clear landing on the emit cycle cancels that frame's count
        for (int i = 0; i < NI; i++) cyc(1'b1, rand_data(), 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b1);
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom % 3) != 0, rand_data(), ($urandom % 60) == 0, ($urandom % 250) != 0);
        end
        idle(15);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
